sync_fifo_flags: RTL and testbench

- Single-clock, parametrised FIFO for intra-domain buffering in the pipelined CPU, e.g. between fetch/decode stages and toward MMIO.
- Unlike the two-clock FIFO it needs no pointer synchronisers, and it holds all MEM_SIZE entries; no slot is wasted.
- Adds an occupancy count, programmable almost-full/almost-empty thresholds, a first-word-fall-through (FWFT) mode, and sticky overflow/underflow error flags.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_mem.sv | 45 ++++
 rtl/sync_fifo_flags.sv | 126 ++++++++++++
 tb/tb_sync_fifo_flags.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO: read-mode constants and the
// pointer-width helper used by both the FIFO top and its memory.
package fifo_pkg;

  localparam int FIFO_STD  = 0;  // registered read, r_valid pulses per read
  localparam int FIFO_FWFT = 1;  // head word shown on r_data while not empty

  // Pointer width: address bits plus one wrap bit.
  function automatic int ptr_len(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Single-clock dual-port storage for the FIFO. Synchronous write port.
// The read port is a registered, enabled read in standard mode, or a plain
// combinational lookup in first-word-fall-through mode.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int MEM_SIZE  = 32,
  parameter int FWFT      = FIFO_STD,
  localparam int ADDR_W   = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 w_en,
  input  logic [ADDR_W-1:0]    w_addr,
  input  logic [DATA_SIZE-1:0] w_data,
  input  logic                 r_en,
  input  logic [ADDR_W-1:0]    r_addr,
  output logic [DATA_SIZE-1:0] r_data
);

  logic [DATA_SIZE-1:0] mem [MEM_SIZE];

  // Storage write; contents are not reset, the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (w_en) mem[w_addr] <= w_data;
  end

  if (FWFT == FIFO_FWFT) begin : g_comb_read
    // The head word is needed in the same cycle it becomes valid.
    assign r_data = mem[r_addr];
    // The registered port's controls have no job in this mode.
    logic unused_rd_ctrl;
    assign unused_rd_ctrl = &{1'b0, reset, r_en};
  end else begin : g_reg_read
    logic [DATA_SIZE-1:0] r_data_q;
    // Registered read: load on an accepted read, hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)     r_data_q <= '0;
      else if (r_en) r_data_q <= mem[r_addr];
    end
    assign r_data = r_data_q;
  end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags,
// optional first-word-fall-through output and sticky error flags.
//
// Handshake: a write is taken on a rising edge where w_en=1 and full=0; a read
// (FWFT: a pop of the head word) is taken where r_en=1 and empty=0. Both are
// judged on the flags as they stood before the edge. Requests made while full
// or empty are dropped and recorded in overflow/underflow. Standard mode:
// r_valid=1 for the single cycle after a taken read, qualifying r_data.
// FWFT mode: r_valid=!empty and r_data is the head word while r_valid=1.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE     = 32,
  parameter int MEM_SIZE      = 32,
  parameter int AFULL_THRESH  = MEM_SIZE - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = FIFO_STD
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         w_en,
  input  logic [DATA_SIZE-1:0]         w_data,
  input  logic                         r_en,
  output logic [DATA_SIZE-1:0]         r_data,
  output logic                         r_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [ptr_len(MEM_SIZE)-1:0] count,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         clr_err
);

  localparam int PTR_W  = ptr_len(MEM_SIZE);
  localparam int ADDR_W = PTR_W - 1;
  localparam logic [PTR_W-1:0] ONE      = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] AFULL_C  = PTR_W'(AFULL_THRESH);
  localparam logic [PTR_W-1:0] AEMPTY_C = PTR_W'(AEMPTY_THRESH);

  if (AFULL_THRESH > MEM_SIZE || AEMPTY_THRESH >= MEM_SIZE) begin : g_bad_thresh
    $error("sync_fifo_flags: threshold out of range for MEM_SIZE");
  end
  if (MEM_SIZE < 2 || (MEM_SIZE & (MEM_SIZE - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_flags: MEM_SIZE must be a power of two, at least 2");
  end

  logic [PTR_W-1:0]     wptr, rptr, count_q;
  logic                 wr_acc, rd_acc;
  logic                 ovf_q, udf_q;
  logic [DATA_SIZE-1:0] mem_rdata;

  // Full/empty come straight from the registered pointers; the wrap bit
  // distinguishes a full buffer from an empty one at equal addresses.
  assign full  = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) && (wptr[ADDR_W] != rptr[ADDR_W]);
  assign empty = (wptr == rptr);

  assign wr_acc = w_en && !full;
  assign rd_acc = r_en && !empty;

  // Pointer and occupancy update; simultaneous read+write leaves count alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + ONE;
      if (rd_acc) rptr <= rptr + ONE;
      if (wr_acc && !rd_acc)      count_q <= count_q + ONE;
      else if (rd_acc && !wr_acc) count_q <= count_q - ONE;
    end
  end

  assign count        = count_q;
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (w_en && full) ovf_q <= 1'b1;
      else if (clr_err) ovf_q <= 1'b0;
      if (r_en && empty) udf_q <= 1'b1;
      else if (clr_err)  udf_q <= 1'b0;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;

  fifo_mem #(
    .DATA_SIZE (DATA_SIZE),
    .MEM_SIZE  (MEM_SIZE),
    .FWFT      (FWFT)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .w_en   (wr_acc),
    .w_addr (wptr[ADDR_W-1:0]),
    .w_data (w_data),
    .r_en   (rd_acc),
    .r_addr (rptr[ADDR_W-1:0]),
    .r_data (mem_rdata)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft_out
    // Head word is live whenever anything is stored; zero when empty.
    assign r_valid = !empty;
    assign r_data  = empty ? '0 : mem_rdata;
  end else begin : g_std_out
    logic r_valid_q;
    // r_valid marks the cycle right after a taken read.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) r_valid_q <= 1'b0;
      else       r_valid_q <= rd_acc;
    end
    assign r_valid = r_valid_q;
    assign r_data  = mem_rdata;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: a standard-mode and a FWFT-mode instance share
// one input stream and are compared against a queue model of the FIFO.
module tb_sync_fifo_flags;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          w_en, r_en, clr_err;
  logic [DW-1:0] w_data;

  logic [DW-1:0] r_data_s, r_data_f;
  logic          r_valid_s, r_valid_f;
  logic          full_s, empty_s, af_s, ae_s, ovf_s, udf_s;
  logic          full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
  logic [CW-1:0] count_s, count_f;

  // Clock and reset
  always #5 clk = ~clk;

  sync_fifo_flags #(.DATA_SIZE(DW), .MEM_SIZE(DEPTH), .AFULL_THRESH(AF),
                    .AEMPTY_THRESH(AE), .FWFT(0)) dut_std (
    .clk(clk), .reset(reset), .w_en(w_en), .w_data(w_data), .r_en(r_en),
    .r_data(r_data_s), .r_valid(r_valid_s), .full(full_s), .empty(empty_s),
    .almost_full(af_s), .almost_empty(ae_s), .count(count_s),
    .overflow(ovf_s), .underflow(udf_s), .clr_err(clr_err));

  sync_fifo_flags #(.DATA_SIZE(DW), .MEM_SIZE(DEPTH), .AFULL_THRESH(AF),
                    .AEMPTY_THRESH(AE), .FWFT(1)) dut_fwft (
    .clk(clk), .reset(reset), .w_en(w_en), .w_data(w_data), .r_en(r_en),
    .r_data(r_data_f), .r_valid(r_valid_f), .full(full_f), .empty(empty_f),
    .almost_full(af_f), .almost_empty(ae_f), .count(count_f),
    .overflow(ovf_f), .underflow(udf_f), .clr_err(clr_err));

  // Reference model and scoreboard state
  logic [DW-1:0] model_q[$];   // words currently stored
  logic [DW-1:0] exp_q[$];     // words due on the standard read port
  logic          exp_ovf, exp_udf;
  logic [DW-1:0] last_rd;
  logic [DW-1:0] exp_d;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            mon_n;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Driver: one clock of stimulus; the model advances with the edge.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    logic wr_ok, rd_ok, ovf_hit, udf_hit;
    @(negedge clk);
    w_en = w; w_data = d; r_en = r; clr_err = c;
    wr_ok   = w && (model_q.size() < DEPTH);
    rd_ok   = r && (model_q.size() > 0);
    ovf_hit = w && (model_q.size() == DEPTH);
    udf_hit = r && (model_q.size() == 0);
    @(posedge clk);
    if (ovf_hit) exp_ovf = 1'b1; else if (c) exp_ovf = 1'b0;
    if (udf_hit) exp_udf = 1'b1; else if (c) exp_udf = 1'b0;
    if (rd_ok) exp_q.push_back(model_q.pop_front());
    if (wr_ok) model_q.push_back(d);
  endtask

  // Monitor: pops the scoreboard on r_valid and checks every flag per cycle.
  always @(negedge clk) begin
    if (!reset) begin
      mon_n = model_q.size();
      if (r_valid_s) begin
        if (exp_q.size() == 0) begin
          chk("std_rvalid_unexpected", 32'(r_valid_s), 32'd0);
        end else begin
          exp_d = exp_q.pop_front();
          chk("std_rdata", 32'(r_data_s), 32'(exp_d));
        end
        last_rd = r_data_s;
      end else begin
        chk("std_rdata_hold", 32'(r_data_s), 32'(last_rd));
      end
      chk("std_rvalid_missing", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      chk("std_count",  32'(count_s), 32'(mon_n));
      chk("std_full",   32'(full_s),  32'(mon_n == DEPTH));
      chk("std_empty",  32'(empty_s), 32'(mon_n == 0));
      chk("std_afull",  32'(af_s),    32'(mon_n >= AF));
      chk("std_aempty", 32'(ae_s),    32'(mon_n <= AE));
      chk("std_ovf",    32'(ovf_s),   32'(exp_ovf));
      chk("std_udf",    32'(udf_s),   32'(exp_udf));
      chk("fwft_count", 32'(count_f), 32'(mon_n));
      chk("fwft_full",  32'(full_f),  32'(mon_n == DEPTH));
      chk("fwft_afull", 32'(af_f),    32'(mon_n >= AF));
      chk("fwft_aempty",32'(ae_f),    32'(mon_n <= AE));
      chk("fwft_ovf",   32'(ovf_f),   32'(exp_ovf));
      chk("fwft_udf",   32'(udf_f),   32'(exp_udf));
      chk("fwft_empty", 32'(empty_f), 32'(mon_n == 0));
      chk("fwft_rvalid",32'(r_valid_f), 32'(mon_n != 0));
      if (mon_n != 0) chk("fwft_head", 32'(r_data_f), 32'(model_q[0]));
    end
  end

  initial begin
    reset = 1'b1; w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; w_data = '0;
    exp_ovf = 1'b0; exp_udf = 1'b0; last_rd = '0;
    #12;
    chk("rst_count",   32'(count_s),   32'd0);
    chk("rst_empty",   32'(empty_s),   32'd1);
    chk("rst_full",    32'(full_s),    32'd0);
    chk("rst_aempty",  32'(ae_s),      32'd1);
    chk("rst_afull",   32'(af_s),      32'd0);
    chk("rst_rvalid",  32'(r_valid_s), 32'd0);
    chk("rst_rdata",   32'(r_data_s),  32'd0);
    chk("rst_ovf",     32'(ovf_s),     32'd0);
    chk("rst_udf",     32'(udf_s),     32'd0);
    chk("rst_fwft_rv", 32'(r_valid_f), 32'd0);
    #1 reset = 1'b0;

    // Fill 0x01..0x08, overflow attempt, drain in order, underflow attempt
    for (int i = 1; i <= DEPTH; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Refill, then overflow coincident with clr_err
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'($urandom_range(0, 255)), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Simultaneous read+write at count 8, 4 and 0
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    while (model_q.size() > 4) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'hC3, 1'b1, 1'b0);
    step(1'b1, 8'h3C, 1'b1, 1'b0);
    while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Randomized traffic with occasional error clears
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) < 55, DW'($urandom_range(0, 255)),
           $urandom_range(0, 99) < 50, $urandom_range(0, 19) == 0);

    // Asynchronous reset between edges at count 5
    while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h70 + i), 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst_count",   32'(count_s),   32'd0);
    chk("arst_empty",   32'(empty_s),   32'd1);
    chk("arst_rvalid",  32'(r_valid_s), 32'd0);
    chk("arst_fwft_rv", 32'(r_valid_f), 32'd0);
    chk("arst_fwft_cnt",32'(count_f),   32'd0);
    model_q.delete(); exp_q.delete();
    exp_ovf = 1'b0; exp_udf = 1'b0; last_rd = '0;
    w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h90 + i), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
